// File: rtl/fir_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fir_pkg
// Description : Shared FIR filter parameters and controller state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package fir_pkg;

    localparam int NTAPS  = 5;
    localparam int DIN_W  = 8;
    localparam int DOUT_W = 16;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        FULL = 3'd2,
        RUN  = 3'd3,
        ERR  = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/fir_datapath.sv
`default_nettype none
// ============================================================================
// Module      : fir_datapath
// Description : FIR sample window, per-tap multipliers, adder and the
//               registered output with its one-cycle strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module fir_datapath #(
    parameter int NTAPS  = 5,
    parameter int DIN_W  = 8,
    parameter int DOUT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [DIN_W-1:0]       data_in,
    input  logic [NTAPS*DIN_W-1:0] coeffs,
    input  logic                   shift,
    input  logic                   clear,
    output logic [DOUT_W-1:0]      data_out,
    output logic                   out_enable
);

    logic [DIN_W-1:0]   samples [NTAPS];
    logic [DIN_W-1:0]   window  [NTAPS];
    logic [2*DIN_W-1:0] prod    [NTAPS];
    logic [DOUT_W-1:0]  sum;

    // Post-shift window: the incoming sample becomes the newest tap.
    always_comb begin
        window[0] = data_in;
        for (int i = 1; i < NTAPS; i++) begin
            window[i] = samples[i-1];
        end
    end

    // Full-width unsigned products, accumulated modulo 2^DOUT_W.
    always_comb begin
        sum = '0;
        for (int i = 0; i < NTAPS; i++) begin
            prod[i] = (2*DIN_W)'(coeffs[i*DIN_W +: DIN_W]) * (2*DIN_W)'(window[i]);
            sum     = sum + DOUT_W'(prod[i]);
        end
    end

    // Sample window: cleared on coefficient reload, shifted on accepted sample.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NTAPS; i++) samples[i] <= '0;
        end else if (clear) begin
            for (int i = 0; i < NTAPS; i++) samples[i] <= '0;
        end else if (shift) begin
            for (int i = 0; i < NTAPS; i++) samples[i] <= window[i];
        end
    end

    // Output register holds between strobes; strobe follows each accepted sample.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_out   <= '0;
            out_enable <= 1'b0;
        end else begin
            out_enable <= shift;
            if (shift) data_out <= sum;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fir.sv
`default_nettype none
// ============================================================================
// Module      : fir
// Description : Loadable-coefficient unsigned FIR filter. Controller FSM,
//               coefficient store and load counter; datapath in fir_datapath.
// Revision    : 1.0 - initial release
// ============================================================================
module fir #(
    parameter int NTAPS  = fir_pkg::NTAPS,
    parameter int DIN_W  = fir_pkg::DIN_W,
    parameter int DOUT_W = fir_pkg::DOUT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DIN_W-1:0]  data_in,
    input  logic              coef_enable,
    input  logic              sample_enable,
    output logic [DOUT_W-1:0] data_out,
    output logic              out_enable,
    output logic              error
);

    import fir_pkg::*;

    localparam int CNT_W = $clog2(NTAPS + 1);

    state_t                   state;
    state_t                   state_next;
    logic [CNT_W-1:0]         count;
    logic [CNT_W-1:0]         count_next;
    logic [DIN_W-1:0]         coeff [NTAPS];
    logic [NTAPS*DIN_W-1:0]   coeffs_flat;
    logic                     coef_store;
    logic [CNT_W-1:0]         coef_idx;
    logic                     accept;
    logic                     clear;

    // Next-state, coefficient-write and datapath-control decode.
    always_comb begin
        state_next = state;
        count_next = count;
        coef_store = 1'b0;
        coef_idx   = '0;
        accept     = 1'b0;
        clear      = 1'b0;
        if (coef_enable && sample_enable) begin
            state_next = ERR;
        end else begin
            case (state)
                IDLE: begin
                    if (coef_enable) begin
                        coef_store = 1'b1;
                        count_next = CNT_W'(1);
                        state_next = (NTAPS == 1) ? FULL : LOAD;
                    end else if (sample_enable) begin
                        state_next = ERR;
                    end
                end
                LOAD: begin
                    if (sample_enable) begin
                        state_next = ERR;
                    end else if (coef_enable) begin
                        coef_store = 1'b1;
                        coef_idx   = count;
                        count_next = count + CNT_W'(1);
                        if (count == CNT_W'(NTAPS - 1)) state_next = FULL;
                    end
                end
                FULL: begin
                    if (coef_enable) begin
                        state_next = ERR;
                    end else begin
                        state_next = RUN;
                        accept     = sample_enable;
                    end
                end
                RUN: begin
                    if (coef_enable) begin
                        // Reload: the new coefficient set starts from tap 0
                        // and the old sample history is discarded.
                        coef_store = 1'b1;
                        count_next = CNT_W'(1);
                        clear      = 1'b1;
                        state_next = (NTAPS == 1) ? FULL : LOAD;
                    end else if (sample_enable) begin
                        accept = 1'b1;
                    end
                end
                ERR:     state_next = ERR;
                default: state_next = ERR;
            endcase
        end
    end

    // State, load counter and registered error flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            count <= '0;
            error <= 1'b0;
        end else begin
            state <= state_next;
            count <= count_next;
            error <= (state_next == ERR);
        end
    end

    generate
        for (genvar g = 0; g < NTAPS; g++) begin : g_coef
            // Coefficient register for tap g; coeff[0] weights the newest sample.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    coeff[g] <= '0;
                end else if (coef_store && (coef_idx == CNT_W'(g))) begin
                    coeff[g] <= data_in;
                end
            end
            assign coeffs_flat[g*DIN_W +: DIN_W] = coeff[g];
        end
    endgenerate

    fir_datapath #(
        .NTAPS  (NTAPS),
        .DIN_W  (DIN_W),
        .DOUT_W (DOUT_W)
    ) dp (
        .clk        (clk),
        .reset      (reset),
        .data_in    (data_in),
        .coeffs     (coeffs_flat),
        .shift      (accept),
        .clear      (clear),
        .data_out   (data_out),
        .out_enable (out_enable)
    );

endmodule
`default_nettype wire

// File: tb/tb_fir.sv
`default_nettype none
// ============================================================================
// Module      : tb_fir
// Description : Scoreboard bench for fir: stimulus pushes expected outputs,
//               a negedge monitor pops and compares on every out_enable.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fir;

    import fir_pkg::*;

    localparam int OW = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [7:0]    data_in = '0;
    logic          coef_enable = 1'b0;
    logic          sample_enable = 1'b0;
    logic [OW-1:0] data_out;
    logic          out_enable;
    logic          error;

    int            compared   = 0;
    int            mismatched = 0;
    logic [OW-1:0] expq [$];

    fir dut (
        .clk           (clk),
        .reset         (reset),
        .data_in       (data_in),
        .coef_enable   (coef_enable),
        .sample_enable (sample_enable),
        .data_out      (data_out),
        .out_enable    (out_enable),
        .error         (error)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every strobe must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (reset === 1'b1 && out_enable === 1'b1) begin
            if (expq.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_strobe: got data_out=%0d with out_enable=1, expected no strobe", data_out);
            end else begin
                check("data_out", 32'(data_out), 32'(expq.pop_front()));
            end
        end
    end

    task automatic step(input logic c, input logic s, input logic [7:0] d);
        coef_enable   = c;
        sample_enable = s;
        data_in       = d;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'd0);
    endtask

    task automatic load5(input logic [7:0] c0, input logic [7:0] c1, input logic [7:0] c2,
                         input logic [7:0] c3, input logic [7:0] c4);
        step(1'b1, 1'b0, c0);
        step(1'b1, 1'b0, c1);
        step(1'b1, 1'b0, c2);
        step(1'b1, 1'b0, c3);
        step(1'b1, 1'b0, c4);
    endtask

    task automatic samp(input logic [7:0] d, input logic [OW-1:0] exp);
        expq.push_back(exp);
        step(1'b0, 1'b1, d);
    endtask

    // Asserts reset between edges and checks the cleared values before any clock edge.
    task automatic apply_reset(input string tag);
        #2 reset = 1'b0;
        #1;
        check({tag, "_state"},      32'(dut.state), 32'(IDLE));
        check({tag, "_count"},      32'(dut.count), 32'd0);
        check({tag, "_data_out"},   32'(data_out),  32'd0);
        check({tag, "_out_enable"}, 32'(out_enable), 32'd0);
        check({tag, "_error"},      32'(error),     32'd0);
        coef_enable   = 1'b0;
        sample_enable = 1'b0;
        data_in       = '0;
        @(posedge clk);
        #1 reset = 1'b1;
    endtask

    task automatic drain(input string tag);
        idle(3);
        check({tag, "_pending"}, 32'(expq.size()), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected bench completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #12;
        apply_reset("por");

        // Reset part-way through a coefficient load.
        step(1'b1, 1'b0, 8'd4);
        step(1'b1, 1'b0, 8'd5);
        step(1'b1, 1'b0, 8'd6);
        apply_reset("midload");

        // Basic filtering: 4,5,6,7,8 against a step of ones.
        load5(8'd4, 8'd5, 8'd6, 8'd7, 8'd8);
        check("load_full_state", 32'(dut.state), 32'(FULL));
        idle(1);
        samp(8'd1, 16'd4);
        samp(8'd1, 16'd9);
        samp(8'd1, 16'd15);
        drain("ones");
        check("hold_data_out", 32'(data_out), 32'd15);
        check("hold_out_enable", 32'(out_enable), 32'd0);

        // Reload from RUN clears history; first sample taken directly in FULL.
        load5(8'd1, 8'd0, 8'd0, 8'd0, 8'd0);
        samp(8'd9, 16'd9);
        samp(8'd2, 16'd2);
        drain("reload");
        check("reload_error", 32'(error), 32'd0);

        // Extra coefficient after a full load is a protocol error and sticky.
        apply_reset("pre_extra");
        load5(8'd4, 8'd5, 8'd6, 8'd7, 8'd8);
        check("pre_extra_error", 32'(error), 32'd0);
        step(1'b1, 1'b0, 8'd9);
        check("extra_coef_error", 32'(error), 32'd1);
        step(1'b0, 1'b1, 8'd3);
        step(1'b0, 1'b1, 8'd3);
        idle(4);
        check("extra_coef_sticky", 32'(error), 32'd1);
        check("extra_coef_state", 32'(dut.state), 32'(ERR));
        drain("err_nostrobe");

        // Sample while IDLE.
        apply_reset("pre_idle_sample");
        step(1'b0, 1'b1, 8'd5);
        check("idle_sample_error", 32'(error), 32'd1);
        idle(2);

        // Both enables together while loading.
        apply_reset("pre_both_load");
        step(1'b1, 1'b0, 8'd1);
        step(1'b1, 1'b0, 8'd2);
        idle(2);
        check("load_hold_count", 32'(dut.count), 32'd2);
        step(1'b1, 1'b1, 8'd3);
        check("both_load_error", 32'(error), 32'd1);

        // Both enables together while running.
        apply_reset("pre_both_run");
        load5(8'd1, 8'd1, 8'd1, 8'd1, 8'd1);
        idle(1);
        step(1'b1, 1'b1, 8'd7);
        check("both_run_error", 32'(error), 32'd1);
        drain("both_nostrobe");

        // Full-scale arithmetic wraps modulo 2^16 (k * 65025 mod 65536).
        apply_reset("pre_max");
        step(1'b1, 1'b0, 8'd255);
        step(1'b1, 1'b0, 8'd255);
        idle(1);
        step(1'b1, 1'b0, 8'd255);
        step(1'b1, 1'b0, 8'd255);
        step(1'b1, 1'b0, 8'd255);
        idle(1);
        samp(8'd255, 16'd65025);
        samp(8'd255, 16'd64514);
        samp(8'd255, 16'd64003);
        samp(8'd255, 16'd63492);
        samp(8'd255, 16'd62981);
        drain("max");
        check("max_error", 32'(error), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire
